decode_ctrl_stage: RTL and testbench

Registered decode/control stage for the pipelined RV32 core, sitting between the IF/ID and ID/EX boundaries. It decodes RV32I instructions, plus RV32M when enabled, into the execute-stage control bundle and ALU operation code. It uses a valid/ready handshake on both sides. It inserts a bubble on load-use hazards against its own ID/EX register, and holds divide/remainder operations in EX for a fixed occupancy.

---
 rtl/decode_ctrl_stage.sv | 238 +++++++++++++++++++++++
 tb/tb_decode_ctrl_stage.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_ctrl_stage.sv
// RV32IM decode/control stage between IF/ID and ID/EX.
// Valid/ready on both sides; load-use bubble and fixed-occupancy divide hold.
module decode_ctrl_stage #(
    parameter bit          ENABLE_M    = 1'b1,
    parameter int unsigned DIV_LATENCY = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_valid,
    input  logic [31:0] instr,
    output logic        id_ready,
    input  logic        flush,
    input  logic        ex_ready,
    output logic        ex_valid,
    output logic        ex_memread,
    output logic        ex_memwrite,
    output logic        ex_regwrite,
    output logic        ex_alusrc,
    output logic        ex_memtoreg,
    output logic        ex_jal,
    output logic        ex_jalr,
    output logic        ex_lui,
    output logic        ex_utype,
    output logic        ex_branch,
    output logic [2:0]  ex_brtype,
    output logic [2:0]  ex_rw_type,
    output logic [4:0]  ex_aluctl,
    output logic [4:0]  ex_rd,
    output logic [4:0]  ex_rs1,
    output logic [4:0]  ex_rs2,
    output logic        ex_illegal,
    output logic        ex_busy
);

    typedef struct packed {
        logic       illegal;
        logic       regwrite;
        logic       memread;
        logic       memwrite;
        logic       alusrc;
        logic       memtoreg;
        logic       jal;
        logic       jalr;
        logic       lui;
        logic       utype;
        logic       branch;
        logic [2:0] func3;
        logic [4:0] aluctl;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
    } ctl_t;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LD   = 7'b0000011;
    localparam logic [6:0] OP_ST   = 7'b0100011;
    localparam logic [6:0] OP_B    = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_LUI  = 7'b0110111;
    localparam logic [6:0] OP_AUI  = 7'b0010111;

    localparam logic [4:0] ALU_ADD  = 5'd0;
    localparam logic [4:0] ALU_SUB  = 5'd1;
    localparam logic [4:0] ALU_SLL  = 5'd2;
    localparam logic [4:0] ALU_SLT  = 5'd3;
    localparam logic [4:0] ALU_SLTU = 5'd4;
    localparam logic [4:0] ALU_XOR  = 5'd5;
    localparam logic [4:0] ALU_SRL  = 5'd6;
    localparam logic [4:0] ALU_SRA  = 5'd7;
    localparam logic [4:0] ALU_OR   = 5'd8;
    localparam logic [4:0] ALU_AND  = 5'd9;

    localparam logic [1:0] S_RUN = 2'd0;
    localparam logic [1:0] S_LU  = 2'd1;
    localparam logic [1:0] S_DIV = 2'd2;

    localparam bit         DIV_HOLD = (DIV_LATENCY > 1);
    localparam logic [7:0] DIV_INIT = 8'(DIV_LATENCY - 1);

    logic [2:0] f3;
    logic [6:0] f7;
    logic       is_r, is_i, is_ld, is_st, is_b;
    logic       is_jal, is_jalr, is_lui, is_aui;
    logic       r_base, r_alt, r_mul, r_ok, legal, alt, div_op;
    logic       use_rs1, use_rs2, hazard, adv;
    logic [4:0] base_op, alu_op;
    ctl_t       dec;

    ctl_t       bun_q, bun_d;
    logic       valid_q, valid_d;
    logic [7:0] cnt_q, cnt_d;
    logic [1:0] st_q, st_d;

    assign f3      = instr[14:12];
    assign f7      = instr[31:25];
    assign is_r    = (instr[6:0] == OP_R);
    assign is_i    = (instr[6:0] == OP_I);
    assign is_ld   = (instr[6:0] == OP_LD);
    assign is_st   = (instr[6:0] == OP_ST);
    assign is_b    = (instr[6:0] == OP_B);
    assign is_jal  = (instr[6:0] == OP_JAL);
    assign is_jalr = (instr[6:0] == OP_JALR);
    assign is_lui  = (instr[6:0] == OP_LUI);
    assign is_aui  = (instr[6:0] == OP_AUI);

    assign r_base = (f7 == 7'b0000000);
    assign r_alt  = (f7 == 7'b0100000);
    assign r_mul  = (f7 == 7'b0000001);
    assign r_ok   = r_base
                  | (r_alt & ((f3 == 3'b000) | (f3 == 3'b101)))
                  | (r_mul & ENABLE_M);
    assign legal  = (is_r & r_ok) | is_i | is_ld | is_st | is_b
                  | is_jal | is_jalr | is_lui | is_aui;
    // I-type shifts take the arithmetic flag from instr[30]
    assign alt    = is_r ? r_alt : instr[30];
    assign div_op = legal & is_r & r_mul & f3[2];

    always_comb begin
        base_op = ALU_ADD;
        unique case (f3)
            3'b000:  base_op = (is_r & r_alt) ? ALU_SUB : ALU_ADD;
            3'b001:  base_op = ALU_SLL;
            3'b010:  base_op = ALU_SLT;
            3'b011:  base_op = ALU_SLTU;
            3'b100:  base_op = ALU_XOR;
            3'b101:  base_op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  base_op = ALU_OR;
            default: base_op = ALU_AND;
        endcase
    end

    always_comb begin
        alu_op = ALU_ADD;
        unique case (1'b1)
            is_r & r_mul:          alu_op = {2'b10, f3};
            (is_r & !r_mul) | is_i: alu_op = base_op;
            is_b:                  alu_op = f3[2] ? (f3[1] ? ALU_SLTU : ALU_SLT) : ALU_SUB;
            default:               alu_op = ALU_ADD;
        endcase
    end

    always_comb begin
        dec          = '0;
        dec.illegal  = !legal;
        dec.regwrite = legal & (is_r | is_i | is_ld | is_jal | is_jalr | is_lui | is_aui);
        dec.memread  = is_ld;
        dec.memtoreg = is_ld;
        dec.memwrite = is_st;
        dec.alusrc   = is_i | is_ld | is_st | is_jalr;
        dec.jal      = is_jal;
        dec.jalr     = is_jalr;
        dec.lui      = is_lui;
        dec.utype    = is_lui | is_aui;
        dec.branch   = is_b;
        dec.func3    = f3;
        dec.aluctl   = legal ? alu_op : ALU_ADD;
        dec.rd       = instr[11:7];
        dec.rs1      = instr[19:15];
        dec.rs2      = instr[24:20];
    end

    assign use_rs1 = is_r | is_i | is_ld | is_st | is_b | is_jalr;
    assign use_rs2 = is_r | is_st | is_b;
    assign hazard  = valid_q & bun_q.memread & (bun_q.rd != 5'd0) & if_valid
                   & ((use_rs1 & (instr[19:15] == bun_q.rd))
                   |  (use_rs2 & (instr[24:20] == bun_q.rd)));
    assign adv      = (!valid_q | ex_ready) & (st_q != S_DIV);
    assign id_ready = rst_n & (flush | (adv & !hazard));

    always_comb begin
        valid_d = valid_q;
        bun_d   = bun_q;
        cnt_d   = cnt_q;
        st_d    = st_q;
        if (flush) begin
            valid_d = 1'b0;
            cnt_d   = 8'd0;
            st_d    = S_RUN;
        end else if (adv & hazard) begin
            valid_d = 1'b0;
            st_d    = S_LU;
        end else if (adv) begin
            st_d    = S_RUN;
            valid_d = if_valid;
            if (if_valid) begin
                bun_d = dec;
                if (div_op & DIV_HOLD) begin
                    cnt_d = DIV_INIT;
                    st_d  = S_DIV;
                end
            end
        end else if (st_q == S_DIV) begin
            // divide releases on the edge the counter hits zero
            cnt_d = cnt_q - 8'd1;
            if (cnt_q <= 8'd1) begin
                cnt_d = 8'd0;
                st_d  = S_RUN;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            bun_q   <= '0;
            cnt_q   <= 8'd0;
            st_q    <= S_RUN;
        end else begin
            valid_q <= valid_d;
            bun_q   <= bun_d;
            cnt_q   <= cnt_d;
            st_q    <= st_d;
        end
    end

    assign ex_valid    = valid_q;
    assign ex_busy     = (st_q == S_DIV);
    assign ex_illegal  = bun_q.illegal;
    assign ex_regwrite = bun_q.regwrite;
    assign ex_memread  = bun_q.memread;
    assign ex_memwrite = bun_q.memwrite;
    assign ex_alusrc   = bun_q.alusrc;
    assign ex_memtoreg = bun_q.memtoreg;
    assign ex_jal      = bun_q.jal;
    assign ex_jalr     = bun_q.jalr;
    assign ex_lui      = bun_q.lui;
    assign ex_utype    = bun_q.utype;
    assign ex_branch   = bun_q.branch;
    assign ex_brtype   = bun_q.func3;
    assign ex_rw_type  = bun_q.func3;
    assign ex_aluctl   = bun_q.aluctl;
    assign ex_rd       = bun_q.rd;
    assign ex_rs1      = bun_q.rs1;
    assign ex_rs2      = bun_q.rs2;

endmodule

// File: tb/tb_decode_ctrl_stage.sv
// Scoreboard bench for decode_ctrl_stage: decode, hazards,
// divide hold, backpressure, flush, async reset, ENABLE_M=0.
module tb_decode_ctrl_stage;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, if_valid, flush, ex_ready, id_ready;
    logic [31:0] instr;
    logic        a_valid, a_mr, a_mw, a_rw, a_as, a_mt, a_jal, a_jalr;
    logic        a_lui, a_ut, a_br, a_ill, a_busy;
    logic [2:0]  a_brt, a_rwt;
    logic [4:0]  a_alu, a_rd, a_rs1, a_rs2;

    logic        iv2;
    logic [31:0] in2;
    logic        b_idr, b_valid, b_mr, b_mw, b_rw, b_as, b_mt, b_jal, b_jalr;
    logic        b_lui, b_ut, b_br, b_ill, b_busy;
    logic [2:0]  b_brt, b_rwt;
    logic [4:0]  b_alu, b_rd, b_rs1, b_rs2;
    logic        c_idr, c_valid, c_mr, c_mw, c_rw, c_as, c_mt, c_jal, c_jalr;
    logic        c_lui, c_ut, c_br, c_ill, c_busy;
    logic [2:0]  c_brt, c_rwt;
    logic [4:0]  c_alu, c_rd, c_rs1, c_rs2;

    decode_ctrl_stage #(.ENABLE_M(1'b1), .DIV_LATENCY(4)) u_a (
        .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .instr(instr),
        .id_ready(id_ready), .flush(flush), .ex_ready(ex_ready),
        .ex_valid(a_valid), .ex_memread(a_mr), .ex_memwrite(a_mw),
        .ex_regwrite(a_rw), .ex_alusrc(a_as), .ex_memtoreg(a_mt),
        .ex_jal(a_jal), .ex_jalr(a_jalr), .ex_lui(a_lui), .ex_utype(a_ut),
        .ex_branch(a_br), .ex_brtype(a_brt), .ex_rw_type(a_rwt),
        .ex_aluctl(a_alu), .ex_rd(a_rd), .ex_rs1(a_rs1), .ex_rs2(a_rs2),
        .ex_illegal(a_ill), .ex_busy(a_busy)
    );

    decode_ctrl_stage #(.ENABLE_M(1'b1), .DIV_LATENCY(1)) u_b (
        .clk(clk), .rst_n(rst_n), .if_valid(iv2), .instr(in2),
        .id_ready(b_idr), .flush(1'b0), .ex_ready(1'b1),
        .ex_valid(b_valid), .ex_memread(b_mr), .ex_memwrite(b_mw),
        .ex_regwrite(b_rw), .ex_alusrc(b_as), .ex_memtoreg(b_mt),
        .ex_jal(b_jal), .ex_jalr(b_jalr), .ex_lui(b_lui), .ex_utype(b_ut),
        .ex_branch(b_br), .ex_brtype(b_brt), .ex_rw_type(b_rwt),
        .ex_aluctl(b_alu), .ex_rd(b_rd), .ex_rs1(b_rs1), .ex_rs2(b_rs2),
        .ex_illegal(b_ill), .ex_busy(b_busy)
    );

    decode_ctrl_stage #(.ENABLE_M(1'b0), .DIV_LATENCY(8)) u_c (
        .clk(clk), .rst_n(rst_n), .if_valid(iv2), .instr(in2),
        .id_ready(c_idr), .flush(1'b0), .ex_ready(1'b1),
        .ex_valid(c_valid), .ex_memread(c_mr), .ex_memwrite(c_mw),
        .ex_regwrite(c_rw), .ex_alusrc(c_as), .ex_memtoreg(c_mt),
        .ex_jal(c_jal), .ex_jalr(c_jalr), .ex_lui(c_lui), .ex_utype(c_ut),
        .ex_branch(c_br), .ex_brtype(c_brt), .ex_rw_type(c_rwt),
        .ex_aluctl(c_alu), .ex_rd(c_rd), .ex_rs1(c_rs1), .ex_rs2(c_rs2),
        .ex_illegal(c_ill), .ex_busy(c_busy)
    );

    logic [36:0] da, db, dc;
    assign da = {a_ill, a_rw, a_mr, a_mw, a_as, a_mt, a_jal, a_jalr, a_lui, a_ut,
                 a_br, a_brt, a_rwt, a_alu, a_rd, a_rs1, a_rs2};
    assign db = {b_ill, b_rw, b_mr, b_mw, b_as, b_mt, b_jal, b_jalr, b_lui, b_ut,
                 b_br, b_brt, b_rwt, b_alu, b_rd, b_rs1, b_rs2};
    assign dc = {c_ill, c_rw, c_mr, c_mw, c_as, c_mt, c_jal, c_jalr, c_lui, c_ut,
                 c_br, c_brt, c_rwt, c_alu, c_rd, c_rs1, c_rs2};

    int n_pass = 0;
    int n_tot  = 0;
    int cyc    = 0;
    int acc_cyc, last_cons, busy_cnt;
    logic [36:0] sbq[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tot++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [4:0] base_alu(input logic [2:0] f);
        case (f)
            3'd0:    return 5'd0;
            3'd1:    return 5'd2;
            3'd2:    return 5'd3;
            3'd3:    return 5'd4;
            3'd4:    return 5'd5;
            3'd5:    return 5'd6;
            3'd6:    return 5'd8;
            default: return 5'd9;
        endcase
    endfunction

    function automatic logic [36:0] ref_dec(input logic [31:0] w, input bit m_en);
        logic [2:0] f3;
        logic [6:0] f7;
        logic ill, rw, mr, mw, as, mt, jl, jr, lu, ut, br;
        logic [4:0] alu;
        f3 = w[14:12];
        f7 = w[31:25];
        {ill, rw, mr, mw, as, mt, jl, jr, lu, ut, br} = '0;
        alu = 5'd0;
        case (w[6:0])
            7'b0110011: begin
                rw = 1;
                if (f7 == 7'b0000001) begin
                    if (m_en) alu = 5'd16 + 5'(f3);
                    else ill = 1;
                end else if (f7 == 7'b0000000) alu = base_alu(f3);
                else if (f7 == 7'b0100000) begin
                    if (f3 == 3'd0) alu = 5'd1;
                    else if (f3 == 3'd5) alu = 5'd7;
                    else ill = 1;
                end else ill = 1;
            end
            7'b0010011: begin
                rw = 1; as = 1;
                alu = (f3 == 3'd5 && w[30]) ? 5'd7 : base_alu(f3);
            end
            7'b0000011: begin rw = 1; mr = 1; mt = 1; as = 1; end
            7'b0100011: begin mw = 1; as = 1; end
            7'b1100011: begin
                br = 1;
                alu = (f3[2:1] == 2'b10) ? 5'd3 : (f3[2:1] == 2'b11) ? 5'd4 : 5'd1;
            end
            7'b1101111: begin rw = 1; jl = 1; end
            7'b1100111: begin rw = 1; jr = 1; as = 1; end
            7'b0110111: begin rw = 1; lu = 1; ut = 1; end
            7'b0010111: begin rw = 1; ut = 1; end
            default:    ill = 1;
        endcase
        if (ill) begin rw = 0; alu = 5'd0; end
        return {ill, rw, mr, mw, as, mt, jl, jr, lu, ut, br, f3, f3, alu,
                w[11:7], w[19:15], w[24:20]};
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // EX side: consume whenever the bundle is valid, not held and not killed
    always @(negedge clk) begin : mon
        logic [36:0] e;
        if (a_busy) busy_cnt++;
        if (rst_n && a_valid && ex_ready && !a_busy && !flush) begin
            if (sbq.size() == 0) chk("sb_underflow", 1, 0);
            else begin
                e = sbq.pop_front();
                chk("bundle", da, e);
            end
            last_cons = cyc;
        end
    end

    task automatic send(input logic [31:0] w, output int stalls);
        int n;
        bit acc;
        instr = w; if_valid = 1'b1; stalls = 0; n = 0; acc = 0;
        while (!acc && n < 40) begin
            @(negedge clk);
            if (id_ready) acc = 1;
            else stalls++;
            @(posedge clk); #1;
            n++;
        end
        if (!acc) chk("accept_timeout", 0, 1);
        else begin
            sbq.push_back(ref_dec(w, 1'b1));
            acc_cyc = cyc;
        end
    endtask

    task automatic send2(input logic [31:0] w);
        in2 = w; iv2 = 1'b1;
        @(negedge clk);
        chk("b_idready", b_idr, 1);
        chk("c_idready", c_idr, 1);
        @(posedge clk); #1;
        iv2 = 1'b0;
        @(negedge clk);
        chk("b_bundle", db, ref_dec(w, 1'b1));
        chk("c_bundle", dc, ref_dec(w, 1'b0));
        chk("b_valid", b_valid, 1);
        chk("b_nobusy", b_busy, 0);
        @(posedge clk); #1;
    endtask

    localparam logic [6:0] R = 7'b0110011;
    logic [31:0] sw_i[8];
    logic [4:0]  sw_a[8];
    logic [3:0]  sw_f[8];
    logic [31:0] lw5, add_h, add_n, divw, xorw;
    int s, s2, t0;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        sw_i[0] = {7'h00, 5'd2, 5'd1, 3'b000, 5'd3, R};          sw_a[0] = 0; sw_f[0] = 4'b1000;
        sw_i[1] = {7'h20, 5'd2, 5'd1, 3'b000, 5'd3, R};          sw_a[1] = 1; sw_f[1] = 4'b1000;
        sw_i[2] = {7'h20, 5'd3, 5'd5, 3'b101, 5'd5, 7'b0010011}; sw_a[2] = 7; sw_f[2] = 4'b1000;
        sw_i[3] = {7'h00, 5'd2, 5'd1, 3'b110, 5'd0, 7'b1100011}; sw_a[3] = 4; sw_f[3] = 4'b0010;
        sw_i[4] = {7'h00, 5'd2, 5'd1, 3'b010, 5'd0, 7'b0100011}; sw_a[4] = 0; sw_f[4] = 4'b0100;
        sw_i[5] = {20'h12345, 5'd4, 7'b0110111};                 sw_a[5] = 0; sw_f[5] = 4'b1001;
        sw_i[6] = {7'h00, 5'd2, 5'd1, 3'b100, 5'd3, R};          sw_a[6] = 5; sw_f[6] = 4'b1000;
        sw_i[7] = {7'h20, 5'd2, 5'd1, 3'b101, 5'd3, R};          sw_a[7] = 7; sw_f[7] = 4'b1000;
        lw5   = {12'd0, 5'd1, 3'b010, 5'd5, 7'b0000011};
        add_h = {7'h00, 5'd2, 5'd5, 3'b000, 5'd6, R};
        add_n = {7'h00, 5'd2, 5'd7, 3'b000, 5'd6, R};
        divw  = {7'h01, 5'd2, 5'd1, 3'b100, 5'd3, R};
        xorw  = {7'h00, 5'd4, 5'd3, 3'b100, 5'd9, R};

        rst_n = 0; if_valid = 0; instr = 0; flush = 0; ex_ready = 1;
        iv2 = 0; in2 = 0; busy_cnt = 0; last_cons = 0; acc_cyc = 0;
        @(negedge clk);
        chk("rst_valid", a_valid, 0);
        chk("rst_bundle", da, 0);
        chk("rst_busy", a_busy, 0);
        chk("rst_idready", id_ready, 0);
        @(posedge clk); #1;
        rst_n = 1;

        for (int i = 0; i < 8; i++) begin
            send(sw_i[i], s);
            if_valid = 0;
            @(negedge clk);
            chk("sweep_alu", a_alu, sw_a[i]);
            chk("sweep_flags", {a_rw, a_mw, a_br, a_ut}, sw_f[i]);
            @(posedge clk); #1;
        end

        send(lw5, s);
        t0 = acc_cyc;
        send(add_h, s2);
        if_valid = 0;
        chk("lu_stall", s2, 1);
        chk("lu_gap", acc_cyc - t0, 2);
        @(posedge clk); #1;
        send(lw5, s);
        t0 = acc_cyc;
        send(add_n, s2);
        if_valid = 0;
        chk("nolu_stall", s2, 0);
        chk("nolu_gap", acc_cyc - t0, 1);
        @(posedge clk); #1;

        busy_cnt = 0;
        send(divw, s);
        t0 = acc_cyc;
        send(add_n, s2);
        if_valid = 0;
        chk("div_stall", s2, 3);
        chk("div_gap", acc_cyc - t0, 4);
        repeat (2) @(posedge clk); #1;
        chk("div_busy_cycles", busy_cnt, 3);

        send(add_n, s);
        ex_ready = 0; instr = xorw; if_valid = 1;
        repeat (3) begin
            @(negedge clk);
            chk("bp_idready", id_ready, 0);
            chk("bp_valid", a_valid, 1);
            chk("bp_stable", da, ref_dec(add_n, 1'b1));
        end
        @(posedge clk); #1;
        ex_ready = 1;
        send(xorw, s);
        if_valid = 0;
        chk("bp_release", s, 0);
        @(posedge clk); #1;

        send(divw, s);
        if_valid = 0;
        @(posedge clk); #1;
        chk("fl_busy_before", a_busy, 1);
        flush = 1;
        @(posedge clk); #1;
        flush = 0;
        chk("fl_valid", a_valid, 0);
        chk("fl_busy", a_busy, 0);
        sbq.delete();
        send(add_n, s);
        if_valid = 0;
        chk("fl_resume", s, 0);
        @(posedge clk); #1;

        send(divw, s);
        if_valid = 0;
        @(posedge clk); #3;
        rst_n = 0;
        #1;
        chk("arst_valid", a_valid, 0);
        chk("arst_bundle", da, 0);
        chk("arst_busy", a_busy, 0);
        chk("arst_idready", id_ready, 0);
        sbq.delete();
        @(posedge clk); #3;
        rst_n = 1;
        @(posedge clk); #1;
        send(add_n, s);
        if_valid = 0;
        @(negedge clk); #1;
        chk("arst_latency", last_cons, acc_cyc);

        send2({7'h01, 5'd3, 5'd2, 3'b000, 5'd1, R});
        chk("m0_mul_ill", c_ill, 1);
        chk("m0_mul_rw", c_rw, 0);
        send2(32'h0000007f);
        chk("bad_opcode_ill", c_ill, 1);
        send2({7'h20, 5'd2, 5'd1, 3'b100, 5'd3, R});
        chk("bad_alt_ill", c_ill, 1);
        send2(divw);
        chk("lat1_div_alu", b_alu, 20);
        chk("lat1_div_legal", b_ill, 0);

        repeat (2) @(posedge clk); #1;
        chk("sb_drain", sbq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
